// File: rtl/medfilt_ctrl_pkg.sv
// rtl/medfilt_ctrl_pkg.sv - shared types and helpers for the median-filter frame sequencer
//
// Purpose: sequencer state encoding and counter-width helper.
// Ports:   none (package).
package medfilt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_PASS     = 2'd2,
    ST_PAD      = 2'd3
  } state_t;

  // Counter width for a count of n positions; never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/medfilt_pos_cnt.sv
// rtl/medfilt_pos_cnt.sv - frame position counter (column/row) with wrap flags
//
// Purpose: tracks the frame position of the next downstream beat.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_adv       advance one position (downstream handshake)
//   o_is_sof    position is (0,0)
//   o_is_eol    position is the last column
//   o_is_eof    position is the last column of the last row
module medfilt_pos_cnt
  import medfilt_ctrl_pkg::*;
#(
  parameter int COLS = 20,
  parameter int ROWS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_adv,
  output logic o_is_sof,
  output logic o_is_eol,
  output logic o_is_eof
);

  localparam int CW = cnt_width(COLS);
  localparam int RW = cnt_width(ROWS);
  localparam logic [CW-1:0] LP_COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] LP_ROW_MAX = RW'(ROWS - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (r_col == LP_COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == LP_ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_is_sof = (r_col == '0) && (r_row == '0);
  assign o_is_eol = (r_col == LP_COL_MAX);
  assign o_is_eof = (r_col == LP_COL_MAX) && (r_row == LP_ROW_MAX);

endmodule

// File: rtl/medfilt_stream_ctrl.sv
// rtl/medfilt_stream_ctrl.sv - whole-frame admission sequencer in front of the 3x3 median filter
//
// Purpose: admits whole frames only, regenerates tlast/tuser from its own
// position counter, pads malformed frames with the last good pixel.
// Optional: MEDFILT_CTRL_STATS_EN adds stat_frames / stat_errs counters.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ctrl_enable           level request to process frames (sampled at frame end)
//   s_axis_*              upstream stream (tuser = SOF, tlast = EOL)
//   m_axis_*              stream toward the filter, markers from counters
//   busy                  high in PASS or PAD
//   frame_done            one-cycle pulse after the last beat of a frame
//   err_fmt               one-cycle pulse on a framing error
//   stat_frames/stat_errs saturating counters (MEDFILT_CTRL_STATS_EN only)
module medfilt_stream_ctrl
  import medfilt_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 20,
  parameter int FRAME_HEIGHT = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_enable,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_fmt
`ifdef MEDFILT_CTRL_STATS_EN
  ,
  output logic [15:0]           stat_frames,
  output logic [15:0]           stat_errs
`endif
);

  state_t                r_state;
  state_t                w_state_nxt;
  state_t                w_after_frame;
  logic [DATA_WIDTH-1:0] r_last_pix;
  logic                  r_frame_done;
  logic                  r_err_fmt;
  logic                  w_hs;
  logic                  w_err;
  logic                  w_frame_end;
  logic                  w_err_take;
  logic                  w_is_sof;
  logic                  w_is_eol;
  logic                  w_is_eof;

  medfilt_pos_cnt #(
    .COLS (FRAME_WIDTH),
    .ROWS (FRAME_HEIGHT)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_adv    (w_hs),
    .o_is_sof (w_is_sof),
    .o_is_eol (w_is_eol),
    .o_is_eof (w_is_eof)
  );

  assign w_hs = m_axis_tvalid & m_axis_tready;

  // A beat is malformed if its tlast disagrees with our column or it claims
  // SOF anywhere other than (0,0).
  assign w_err = s_axis_tvalid &
                 ((s_axis_tlast != w_is_eol) | (s_axis_tuser & ~w_is_sof));

  // ctrl_enable only matters at frame boundaries.
  assign w_after_frame = ctrl_enable ? ST_WAIT_SOF : ST_IDLE;

  always_comb begin
    w_state_nxt   = r_state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    w_frame_end   = 1'b0;
    w_err_take    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ctrl_enable) w_state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        m_axis_tdata = s_axis_tdata;
        if (!ctrl_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (!s_axis_tuser) begin
          s_axis_tready = 1'b1;       // pre-SOF junk is drained
        end else if (w_err) begin
          s_axis_tready = 1'b1;       // bad SOF dropped, keep hunting
          w_err_take    = 1'b1;
        end else begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          if (s_axis_tvalid && m_axis_tready) w_state_nxt = ST_PASS;
        end
      end
      ST_PASS: begin
        m_axis_tdata = s_axis_tdata;
        if (w_err) begin
          s_axis_tready = 1'b1;
          w_err_take    = 1'b1;
          w_state_nxt   = ST_PAD;
        end else begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          if (s_axis_tvalid && m_axis_tready && w_is_eof) begin
            w_frame_end = 1'b1;
            w_state_nxt = w_after_frame;
          end
        end
      end
      ST_PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = r_last_pix;
        if (m_axis_tready && w_is_eof) begin
          w_frame_end = 1'b1;
          w_state_nxt = w_after_frame;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_pix   <= '0;
      r_frame_done <= 1'b0;
      r_err_fmt    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_frame_end;
      r_err_fmt    <= w_err_take;
      if (w_hs && (r_state != ST_PAD)) r_last_pix <= s_axis_tdata;
    end
  end

  assign m_axis_tlast = w_is_eol;
  assign m_axis_tuser = w_is_sof;
  assign busy         = (r_state == ST_PASS) || (r_state == ST_PAD);
  assign frame_done   = r_frame_done;
  assign err_fmt      = r_err_fmt;

`ifdef MEDFILT_CTRL_STATS_EN
  logic        r_en_d;
  logic [15:0] r_stat_frames;
  logic [15:0] r_stat_errs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d        <= 1'b0;
      r_stat_frames <= '0;
      r_stat_errs   <= '0;
    end else begin
      r_en_d <= ctrl_enable;
      if (r_en_d && !ctrl_enable) begin
        r_stat_frames <= '0;
        r_stat_errs   <= '0;
      end else begin
        if (w_frame_end && (r_stat_frames != 16'hFFFF)) r_stat_frames <= r_stat_frames + 16'd1;
        if (w_err_take && (r_stat_errs != 16'hFFFF)) r_stat_errs <= r_stat_errs + 16'd1;
      end
    end
  end

  assign stat_frames = r_stat_frames;
  assign stat_errs   = r_stat_errs;
`endif

endmodule

// File: tb/tb_medfilt_stream_ctrl.sv
// tb/tb_medfilt_stream_ctrl.sv - directed self-checking bench for medfilt_stream_ctrl
module tb_medfilt_stream_ctrl;

  localparam int FW   = 20;
  localparam int FH   = 20;
  localparam int NPIX = FW * FH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ctrl_enable = 1'b0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       busy;
  logic       frame_done;
  logic       err_fmt;
`ifdef MEDFILT_CTRL_STATS_EN
  logic [15:0] stat_frames;
  logic [15:0] stat_errs;
`endif

  int         total = 0;
  int         bad = 0;
  int         fd_cnt = 0;
  int         err_cnt = 0;
  logic [9:0] q[$];
  bit         bp = 1'b0;
  bit         gaps = 1'b0;

  always #5 clk = ~clk;

  medfilt_stream_ctrl #(
    .DATA_WIDTH   (8),
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctrl_enable   (ctrl_enable),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_fmt       (err_fmt)
`ifdef MEDFILT_CTRL_STATS_EN
    ,
    .stat_frames   (stat_frames),
    .stat_errs     (stat_errs)
`endif
  );

  // Downstream observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (frame_done) fd_cnt++;
      if (err_fmt) err_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int base, input int r, input int c);
    return 8'((base + r * 7 + c * 13) & 255);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    m_axis_tready = bp ? ~m_axis_tready : 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic u);
    int n;
    n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) step();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    @(negedge clk);
    while (!s_axis_tready && n < 2000) begin
      step();
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=%0d expected<2000", n);
    end
    step();
    s_axis_tvalid = 1'b0;
  endtask

  // err_at: beat sent with a wrong tlast, after which sending stops.
  // dis_at: ctrl_enable dropped before this beat. stop_at: stop before this beat.
  task automatic send_frame(input int base, input int err_at, input int dis_at, input int stop_at);
    for (int i = 0; i < NPIX; i++) begin
      int r = i / FW;
      int c = i % FW;
      if (i == stop_at) return;
      if (i == dis_at) ctrl_enable = 1'b0;
      if (i == err_at) begin
        send(pix(base, r, c), 1'b1, 1'b0);
        return;
      end
      send(pix(base, r, c), (c == FW - 1), (i == 0));
    end
  endtask

  task automatic wait_fd(input int target);
    int n;
    n = 0;
    while (fd_cnt < target && n < 3000) begin
      step();
      n++;
    end
    step();
    step();
    chk("frame_done_count", fd_cnt, target);
  endtask

  // pad_at: first beat index carrying the padding pixel (NPIX when none).
  task automatic check_frame(input int base, input int pad_at);
    logic [7:0] pv;
    logic [9:0] e;
    chk("beat_count", q.size(), NPIX);
    pv = pix(base, (pad_at - 1) / FW, (pad_at - 1) % FW);
    for (int i = 0; i < NPIX && i < q.size(); i++) begin
      e = {(i == 0), (i % FW == FW - 1), (i >= pad_at) ? pv : pix(base, i / FW, i % FW)};
      chk($sformatf("beat%0d_base%0d", i, base), q[i], e);
    end
    q.delete();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_fmt", err_fmt, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ctrl_enable = 1'b1;
    step();
    step();

    // Clean frame
    send_frame(10, -1, -1, -1);
    wait_fd(1);
    chk("clean_err", err_cnt, 0);
    check_frame(10, NPIX);

    // Pre-SOF junk is dropped
    for (int k = 0; k < 5; k++) send(8'(8'hA0 + k), 1'b0, 1'b0);
    chk("junk_dropped", q.size(), 0);
    send_frame(33, -1, -1, -1);
    wait_fd(2);
    check_frame(33, NPIX);

    // Early tlast at row 3 col 10 -> pad 330 beats
    send_frame(50, 3 * FW + 10, -1, -1);
    wait_fd(3);
    chk("early_tlast_err", err_cnt, 1);
    check_frame(50, 3 * FW + 10);
    send_frame(90, -1, -1, -1);
    wait_fd(4);
    chk("after_pad_err", err_cnt, 1);
    check_frame(90, NPIX);

    // Backpressure with upstream gaps
    bp = 1'b1;
    gaps = 1'b1;
    send_frame(120, -1, -1, -1);
    wait_fd(5);
    bp = 1'b0;
    gaps = 1'b0;
    step();
    check_frame(120, NPIX);

    // Disable mid-frame: frame completes, then IDLE
    send_frame(160, -1, 100, -1);
    wait_fd(6);
    check_frame(160, NPIX);
    @(negedge clk);
    chk("disabled_s_tready", s_axis_tready, 0);
    chk("disabled_busy", busy, 0);
    step();
    ctrl_enable = 1'b1;
    step();
    step();
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    chk("reenable_junk_dropped", q.size(), 0);
    send_frame(200, -1, -1, -1);
    wait_fd(7);
    check_frame(200, NPIX);

    // Reset mid-frame at beat 150
    send_frame(230, -1, -1, 150);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_axis_tvalid, 0);
    chk("midrst_s_tready", s_axis_tready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_m_tlast", m_axis_tlast, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    step();
    step();
`ifdef MEDFILT_CTRL_STATS_EN
    chk("stat_frames_after_rst", stat_frames, 0);
    chk("stat_errs_after_rst", stat_errs, 0);
`endif
    send_frame(240, -1, -1, -1);
    wait_fd(8);
    check_frame(240, NPIX);
    chk("final_err_count", err_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
